// File: rtl/instr_fetch_pkg.sv
// core_defines for the fetch stage: NOP encoding, fetch FSM encodings and the
// {addr, instr} prefetch entry shared by instr_fetch and fetch_fifo.
`ifndef INSTR_FETCH_CORE_DEFINES
`define INSTR_FETCH_CORE_DEFINES
`define INSTR_NOP 32'h0000_0013
`define IF_IDLE   2'd0
`define IF_REQ    2'd1
`define IF_WAIT   2'd2
`define IF_DROP   2'd3
`endif

package instr_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = `INSTR_NOP;

    localparam logic [1:0] IF_IDLE = `IF_IDLE;
    localparam logic [1:0] IF_REQ  = `IF_REQ;
    localparam logic [1:0] IF_WAIT = `IF_WAIT;
    localparam logic [1:0] IF_DROP = `IF_DROP;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of targets are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for the fetch stage: synchronous FIFO of {addr, instr}
// entries. Flush wins over push; a pop on an empty FIFO is ignored.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Hidamari instruction fetch: PC, single-outstanding req/gnt/rvalid fetch and a
// prefetch FIFO feeding decode. Optional FETCH_BYPASS_EN presents rvalid data directly.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_mem_req_out,
    output logic [31:0] if_mem_addr_out,
    input  logic        if_mem_gnt_in,
    input  logic        if_mem_rvalid_in,
    input  logic [31:0] if_mem_rdata_in,
    input  logic        if_jump_en_in,
    input  logic [31:0] if_jump_addr_in,
    input  logic        if_stall_in,
    output logic [31:0] if_instr_addr_out,
    output logic [31:0] if_instr_out,
    output logic        if_instr_valid_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  rsp;
    fetch_entry_t  out;
    logic          fifo_valid;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          valid;

    assign if_mem_req_out  = (state_q == IF_REQ) && (count < CW'(FIFO_DEPTH));
    assign if_mem_addr_out = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                if (if_mem_req_out && if_mem_gnt_in) begin
                    req_pc_d = pc_q;
                    state_d  = if_jump_en_in ? IF_DROP : IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (if_mem_rvalid_in) begin
                    state_d = IF_REQ;
                    if (!if_jump_en_in) pc_d = pc_q + 32'd4;
                end else if (if_jump_en_in) begin
                    state_d = IF_DROP;
                end
            end
            IF_DROP: begin
                if (if_mem_rvalid_in) state_d = IF_REQ;
            end
            default: state_d = IF_IDLE;
        endcase
        // A redirect overrides any sequential PC update.
        if (if_jump_en_in) pc_d = word_align(if_jump_addr_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IF_IDLE;
            pc_q     <= word_align(RESET_PC);
            req_pc_q <= word_align(RESET_PC);
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign fifo_valid = (count != '0);
    assign accept     = (state_q == IF_WAIT) && if_mem_rvalid_in && !if_jump_en_in;
    assign rsp        = '{addr: req_pc_q, instr: if_mem_rdata_in};

`ifdef FETCH_BYPASS_EN
    // Response lands straight on the outputs when nothing older is queued.
    assign bypass = accept && !fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push  = accept && (!bypass || if_stall_in);
    assign valid = (fifo_valid || bypass) && !if_jump_en_in;
    assign pop   = fifo_valid && !if_jump_en_in && !if_stall_in;
    assign out   = bypass ? rsp : head;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (if_jump_en_in),
        .wdata (rsp),
        .head  (head),
        .count (count)
    );

    assign if_instr_valid_out = valid;
    assign if_instr_addr_out  = valid ? out.addr  : 32'h0;
    assign if_instr_out       = valid ? out.instr : INSTR_NOP;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a memory responder, randomized stall/jump
// traffic, and an expected stream of sequential words restarting at each redirect.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req, gnt, rvalid, jump, stall, valid;
    logic [31:0] addr, rdata, jaddr, iaddr, instr;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_mem_req_out     (req),
        .if_mem_addr_out    (addr),
        .if_mem_gnt_in      (gnt),
        .if_mem_rvalid_in   (rvalid),
        .if_mem_rdata_in    (rdata),
        .if_jump_en_in      (jump),
        .if_jump_addr_in    (jaddr),
        .if_stall_in        (stall),
        .if_instr_addr_out  (iaddr),
        .if_instr_out       (instr),
        .if_instr_valid_out (valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] gen_next;

    int          gnt_pct = 100, lat_max = 0, fix_lat = -1, stall_pct = 0, jump_pct = 0;
    bit          force_stall = 0, force_jump = 0, jor = 0, jor_hit = 0;
    logic [31:0] force_jaddr = 32'h0;
    bit          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2], 2'b11} ^ 32'h9E37_79B0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_next);
            gen_next = gen_next + 32'd4;
        end
    endtask

    // Decode must see consecutive words starting at the (aligned) target.
    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        gen_next = a & 32'hFFFF_FFFC;
        top_up();
    endtask

    // Monitor: compares whatever the DUT presents, away from the rising edge.
    initial begin
        logic        hv;
        logic [31:0] ha, hi, e;
        hv = 0; ha = 0; hi = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 0;
            end else begin
                if (jump) begin
                    chk("jump_kill_valid", 32'(valid), 32'd0);
                end else if (valid) begin
                    if (hv) begin
                        chk("stall_hold_addr", iaddr, ha);
                        chk("stall_hold_instr", instr, hi);
                    end
                    if (!stall) begin
                        e = exp_q.pop_front();
                        top_up();
                        pops++;
                        chk("out_addr", iaddr, e);
                        chk("out_instr", instr, mem_word(e));
                    end
                end else begin
                    if (hv) chk("stall_hold_valid", 32'(valid), 32'd1);
                    chk("idle_instr", instr, NOP);
                    chk("idle_addr", iaddr, 32'h0);
                end
                hv = valid && stall && !jump;
                ha = iaddr;
                hi = instr;
            end
        end
    end

    // One cycle of stimulus: memory responder, stall and redirect.
    task automatic step();
        @(posedge clk);
        #1;
        gnt    = 0;
        rvalid = 0;
        rdata  = $urandom;
        jump   = 0;
        stall  = force_stall || ($urandom_range(99) < stall_pct);
        if (pend) begin
            chk("one_outstanding", 32'(req), 32'd0);
            if (pend_lat == 0) begin
                rvalid = 1;
                rdata  = mem_word(pend_addr);
                pend   = 0;
            end else begin
                pend_lat--;
            end
        end else if (req && ($urandom_range(99) < gnt_pct)) begin
            gnt       = 1;
            pend      = 1;
            pend_addr = addr;
            pend_lat  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(lat_max));
        end
        if (force_jump) begin
            jump = 1; jaddr = force_jaddr; force_jump = 0;
        end else if (jor && rvalid && valid) begin
            jump = 1; jaddr = $urandom; jor_hit = 1;
        end else if ($urandom_range(99) < jump_pct) begin
            jump  = 1;
            jaddr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        end
        if (jump) restart(jaddr);
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        step();
        while (!gnt && n < 40) begin
            step();
            n++;
        end
        chk(name, 32'(gnt), 32'd1);
    endtask

    initial begin
        int n;
        gnt = 0; rvalid = 0; rdata = 0; jump = 0; jaddr = 0; stall = 0;
        restart(RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_req_addr", addr, RESET_PC);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_addr", iaddr, 32'h0);
        rst = 0;

        // Zero-wait memory from reset.
        step();
        chk("first_req", 32'(req), 32'd1);
        chk("first_req_addr", addr, RESET_PC);
        chk("first_gnt", 32'(gnt), 32'd1);
        step();
        chk("valid_n1", 32'(valid), 32'(FIRST_LAT == 1));
        step();
        chk("valid_n2", 32'(valid), 32'(FIRST_LAT == 2));
        chk("req_n2", 32'(req), 32'd1);
        chk("req_addr_n2", addr, 32'd4);

        // Stall long enough to fill the FIFO.
        force_stall = 1;
        repeat (6) step();
        chk("full_req_low", 32'(req), 32'd0);
        chk("full_valid", 32'(valid), 32'd1);
        force_stall = 0;
        repeat (10) step();

        // Redirect while a response is pending.
        fix_lat = 2;
        wait_gnt("wait_gnt_a");
        force_jump = 1; force_jaddr = 32'h0000_0102;
        step();
        fix_lat = -1;
        wait_gnt("wait_gnt_b");
        chk("jump_req_addr", addr, 32'h0000_0100);
        repeat (8) step();

        // Redirect coinciding with rvalid while a head is presented.
        force_stall = 1; jor = 1; jor_hit = 0; n = 0;
        while (!jor_hit && n < 40) begin
            step();
            n++;
        end
        chk("jump_on_rvalid_seen", 32'(jor_hit), 32'd1);
        force_stall = 0; jor = 0;
        step();
        chk("flush_empty", 32'(valid), 32'd0);
        repeat (6) step();

        // Address wrap.
        force_jump = 1; force_jaddr = 32'hFFFF_FFF8;
        repeat (12) step();

        // Reset while a response is outstanding, then a stale response.
        fix_lat = 3;
        wait_gnt("wait_gnt_c");
        @(posedge clk);
        #1;
        gnt = 0; rvalid = 0; jump = 0; stall = 0; rst = 1;
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_addr", addr, RESET_PC);
        pend = 0; fix_lat = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        restart(RESET_PC);
        @(posedge clk);
        #1;
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        chk("post_rst_req", 32'(req), 32'd1);
        chk("post_rst_addr", addr, RESET_PC);
        repeat (10) step();

        // Randomized traffic.
        gnt_pct = 70; lat_max = 3; stall_pct = 30; jump_pct = 3;
        repeat (2000) step();
        stall_pct = 0; jump_pct = 0;
        repeat (20) step();
        chk("progress", 32'(pops > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
